// File: rtl/uart_pkg.sv
// Shared UART definitions used by the 8-N-1 receiver and transmitter.
// Holds the state encoding, default bit period and frame data width.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 217;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4,
    S_BREAK   = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; 2-cycle latency, no backpressure.
// Kept in its own file so clock-domain-crossing waivers attach to a single place.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = i_Async;
    sync_d = meta_q;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx2.sv
// 8-N-1 UART receiver: start validated at mid-bit, data sampled at bit centres, stop checked.
// DV / framing-error pulse one cycle after the stop sample; no backpressure, byte held until next good frame.
module uart_rx2
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

  logic line;

  uart_rx_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_Rx_Serial),
    .o_Sync  (line)
  );

  uart_state_e      state_d,   state_q;
  logic [CNT_W-1:0] cnt_d,     cnt_q;
  logic [2:0]       bit_idx_d, bit_idx_q;
  logic [7:0]       shift_d,   shift_q;
  logic [7:0]       byte_d,    byte_q;
  logic             dv_d,      dv_q;
  logic             ferr_d,    ferr_q;
  logic             active_d,  active_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    active_d  = active_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!line) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          if (!line) begin
            state_d = S_DATA;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = line;
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (line) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CLEANUP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      // A held-low line must return high before another start is accepted.
      S_BREAK: begin
        cnt_d = '0;
        if (line) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d    = '0;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule
